// File: rtl/fir_sym_pkg.sv
// rtl/fir_sym_pkg.sv - shared width helpers and saturation limits for DMSP FIR filters
package fir_sym_pkg;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

    // Pre-added sample (DW+1) times coefficient (CW).
    function automatic int prod_w(input int dw, input int cw);
        return dw + 1 + cw;
    endfunction

    // Full-precision sum of TAPS/2 products; nothing is dropped before the output stage.
    function automatic int acc_w(input int dw, input int cw, input int taps);
        return dw + cw + 1 + clog2(taps / 2);
    endfunction

    function automatic longint sat_hi(input int dw);
        return (longint'(1) << (dw - 1)) - 1;
    endfunction

    function automatic longint sat_lo(input int dw);
        return -(longint'(1) << (dw - 1));
    endfunction

endpackage

// File: rtl/fir_round_sat.sv
// rtl/fir_round_sat.sv - round-half-up, arithmetic shift and saturate an accumulator to DW bits
module fir_round_sat
    import fir_sym_pkg::*;
#(
    parameter int AW    = 46,
    parameter int DW    = 20,
    parameter int SHIFT = 19
) (
    input  logic signed [AW-1:0] acc_i,
    output logic signed [DW-1:0] data_o,
    output logic                 sat_o
);

    // One guard bit so adding the rounding constant can never wrap.
    localparam int RW = AW + 1;
    localparam logic signed [RW-1:0] HI = RW'(sat_hi(DW));
    localparam logic signed [RW-1:0] LO = RW'(sat_lo(DW));

    logic signed [RW-1:0] ext;
    logic signed [RW-1:0] rnd;

    assign ext = RW'(acc_i);

    generate
        if (SHIFT > 0) begin : g_round
            localparam logic signed [RW-1:0] HALF = RW'(1) <<< (SHIFT - 1);
            assign rnd = (ext + HALF) >>> SHIFT;
        end else begin : g_pass
            assign rnd = ext;
        end
    endgenerate

    // Clip to the signed DW-bit range and flag when clipping happened.
    always_comb begin
        sat_o  = 1'b0;
        data_o = rnd[DW-1:0];
        if (rnd > HI) begin
            data_o = HI[DW-1:0];
            sat_o  = 1'b1;
        end else if (rnd < LO) begin
            data_o = LO[DW-1:0];
            sat_o  = 1'b1;
        end
    end

endmodule

// File: rtl/fir_sym_decim.sv
// rtl/fir_sym_decim.sv - symmetric linear-phase FIR with loadable coefficients and decimation
module fir_sym_decim
    import fir_sym_pkg::*;
#(
    parameter int DW    = 20,
    parameter int CW    = 21,
    parameter int TAPS  = 24,
    parameter int DECIM = 1,
    parameter int SHIFT = 19
) (
    input  logic                     clk,
    input  logic                     reset_b,
    input  logic                     clear,
    input  logic                     in_valid,
    input  logic signed [DW-1:0]     data_in,
    input  logic                     coef_we,
    input  logic [clog2(TAPS/2)-1:0] coef_addr,
    input  logic signed [CW-1:0]     coef_data,
    output logic                     out_valid,
    output logic signed [DW-1:0]     data_out,
    output logic                     out_sat
);

    localparam int NC = TAPS / 2;
    localparam int SW = DW + 1;
    localparam int PW = prod_w(DW, CW);
    localparam int AW = acc_w(DW, CW, TAPS);
    localparam logic [3:0] PH_LAST = 4'(DECIM - 1);

    logic signed [SW-1:0] del_q  [TAPS];
    logic signed [CW-1:0] coef_q [NC];
    logic signed [SW-1:0] pre_d  [NC];
    logic signed [SW-1:0] pre_q  [NC];
    logic signed [PW-1:0] prod_d [NC];
    logic signed [PW-1:0] prod_q [NC];
    logic signed [AW-1:0] acc_d;
    logic signed [AW-1:0] acc_q;
    logic [3:0]           phase_q;
    logic                 v0_q, v1_q, v2_q, v3_q;
    logic signed [DW-1:0] rs_data;
    logic                 rs_sat;

    // Delay line: shifts only on accepted samples; clear flushes it.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            for (int i = 0; i < TAPS; i++) del_q[i] <= '0;
        end else if (clear) begin
            for (int i = 0; i < TAPS; i++) del_q[i] <= '0;
        end else if (in_valid) begin
            del_q[0] <= SW'(data_in);
            for (int i = 1; i < TAPS; i++) del_q[i] <= del_q[i-1];
        end
    end

    // Coefficient bank; out-of-range indices are dropped, clear leaves it alone.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            for (int i = 0; i < NC; i++) coef_q[i] <= '0;
        end else if (coef_we && (int'(coef_addr) < NC)) begin
            coef_q[coef_addr] <= coef_data;
        end
    end

    // Decimation phase and the valid tag that rides alongside the data pipeline.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            phase_q <= '0;
            v0_q    <= 1'b0;
            v1_q    <= 1'b0;
            v2_q    <= 1'b0;
            v3_q    <= 1'b0;
        end else if (clear) begin
            phase_q <= '0;
            v0_q    <= 1'b0;
            v1_q    <= 1'b0;
            v2_q    <= 1'b0;
            v3_q    <= 1'b0;
        end else begin
            v0_q <= in_valid && (phase_q == 4'd0);
            v1_q <= v0_q;
            v2_q <= v1_q;
            v3_q <= v2_q;
            if (in_valid) phase_q <= (phase_q == PH_LAST) ? 4'd0 : phase_q + 4'd1;
        end
    end

    // Fold symmetric taps, then multiply each pair by its shared coefficient.
    for (genvar i = 0; i < NC; i++) begin : g_tap
        assign pre_d[i]  = del_q[i] + del_q[TAPS-1-i];
        assign prod_d[i] = PW'(pre_q[i]) * PW'(coef_q[i]);
    end

    // Full-width sum of all products.
    always_comb begin
        acc_d = '0;
        for (int i = 0; i < NC; i++) acc_d = acc_d + AW'(prod_q[i]);
    end

    // Pre-add, multiply and accumulate registers advance every cycle.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            for (int i = 0; i < NC; i++) begin
                pre_q[i]  <= '0;
                prod_q[i] <= '0;
            end
            acc_q <= '0;
        end else begin
            for (int i = 0; i < NC; i++) begin
                pre_q[i]  <= pre_d[i];
                prod_q[i] <= prod_d[i];
            end
            acc_q <= acc_d;
        end
    end

    fir_round_sat #(
        .AW    (AW),
        .DW    (DW),
        .SHIFT (SHIFT)
    ) u_round_sat (
        .acc_i  (acc_q),
        .data_o (rs_data),
        .sat_o  (rs_sat)
    );

    // Output register: data and sat flag hold between valid pulses.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            out_valid <= 1'b0;
            data_out  <= '0;
            out_sat   <= 1'b0;
        end else if (clear) begin
            out_valid <= 1'b0;
        end else begin
            out_valid <= v3_q;
            if (v3_q) begin
                data_out <= rs_data;
                out_sat  <= rs_sat;
            end
        end
    end

endmodule

// File: tb/tb_fir_sym_decim.sv
// tb/tb_fir_sym_decim.sv - randomized and directed check of fir_sym_decim against a direct-form model
module tb_fir_sym_decim;

    localparam int DW   = 20;
    localparam int CW   = 21;
    localparam int TAPS = 24;
    localparam int NC   = TAPS / 2;

    logic                 clk = 1'b0;
    logic                 reset_b = 1'b0;
    logic                 clear = 1'b0;
    logic                 in_valid = 1'b0;
    logic signed [DW-1:0] data_in = '0;
    logic                 coef_we = 1'b0;
    logic [3:0]           coef_addr = '0;
    logic signed [CW-1:0] coef_data = '0;

    logic                 ov [3];
    logic signed [DW-1:0] dq [3];
    logic                 sq [3];

    always #5 clk = ~clk;

    fir_sym_decim #(.DW(DW), .CW(CW), .TAPS(TAPS), .DECIM(1), .SHIFT(0)) u_dut_a (
        .clk(clk), .reset_b(reset_b), .clear(clear), .in_valid(in_valid), .data_in(data_in),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
        .out_valid(ov[0]), .data_out(dq[0]), .out_sat(sq[0]));

    fir_sym_decim #(.DW(DW), .CW(CW), .TAPS(TAPS), .DECIM(1), .SHIFT(19)) u_dut_b (
        .clk(clk), .reset_b(reset_b), .clear(clear), .in_valid(in_valid), .data_in(data_in),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
        .out_valid(ov[1]), .data_out(dq[1]), .out_sat(sq[1]));

    fir_sym_decim #(.DW(DW), .CW(CW), .TAPS(TAPS), .DECIM(3), .SHIFT(1)) u_dut_c (
        .clk(clk), .reset_b(reset_b), .clear(clear), .in_valid(in_valid), .data_in(data_in),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
        .out_valid(ov[2]), .data_out(dq[2]), .out_sat(sq[2]));

    typedef struct {
        int     k;
        int     due;
        longint v;
        bit     s;
    } exp_t;

    int     sh [3] = '{0, 19, 1};
    int     dc [3] = '{1, 1, 3};
    longint hist [TAPS];
    longint cm [NC];
    int     phase [3];
    longint last_v [3];
    bit     last_s [3];
    exp_t   eq [$];
    longint cap_a [$];
    int     capcyc_a [$];
    longint cap_c [$];
    int     capcyc_c [$];
    int     cyc = 0;
    int     n_chk = 0;
    int     n_fail = 0;

    task automatic check(input string tag, input longint got, input longint expv);
        n_chk++;
        if (got !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, expv, cyc);
        end
    endtask

    function automatic void model_round_sat(input longint acc, input int s, output longint r, output bit sat);
        longint hi, lo;
        hi = (longint'(1) << (DW - 1)) - 1;
        lo = -(longint'(1) << (DW - 1));
        if (s == 0) r = acc;
        else        r = (acc + (longint'(1) << (s - 1))) >>> s;
        sat = 1'b0;
        if (r > hi) begin r = hi; sat = 1'b1; end
        if (r < lo) begin r = lo; sat = 1'b1; end
    endfunction

    function automatic void model_reset();
        for (int t = 0; t < TAPS; t++) hist[t] = 0;
        for (int i = 0; i < NC; i++) cm[i] = 0;
        for (int k = 0; k < 3; k++) begin
            phase[k]  = 0;
            last_v[k] = 0;
            last_s[k] = 1'b0;
        end
        eq.delete();
    endfunction

    // Direct-form view: tap t of a symmetric filter uses coefficient min(t, TAPS-1-t).
    function automatic void model_edge();
        longint acc, r;
        bit     s;
        exp_t   e;
        if (coef_we && (int'(coef_addr) < NC)) cm[coef_addr] = longint'(coef_data);
        if (clear) begin
            for (int t = 0; t < TAPS; t++) hist[t] = 0;
            for (int k = 0; k < 3; k++) phase[k] = 0;
            eq.delete();
        end else if (in_valid) begin
            for (int t = TAPS - 1; t > 0; t--) hist[t] = hist[t-1];
            hist[0] = longint'(data_in);
            acc = 0;
            for (int t = 0; t < TAPS; t++) acc += hist[t] * cm[(t < NC) ? t : TAPS - 1 - t];
            for (int k = 0; k < 3; k++) begin
                if (phase[k] == 0) begin
                    model_round_sat(acc, sh[k], r, s);
                    e.k = k; e.due = cyc + 4; e.v = r; e.s = s;
                    eq.push_back(e);
                end
                phase[k] = (phase[k] + 1) % dc[k];
            end
        end
    endfunction

    function automatic int find_exp(input int k);
        for (int j = 0; j < eq.size(); j++) if (eq[j].k == k) return j;
        return -1;
    endfunction

    task automatic check_all();
        int j;
        for (int k = 0; k < 3; k++) begin
            j = find_exp(k);
            if (j >= 0 && eq[j].due == cyc) begin
                check($sformatf("valid%0d", k), longint'(ov[k]), 1);
                check($sformatf("data%0d", k), longint'(dq[k]), eq[j].v);
                check($sformatf("sat%0d", k), longint'(sq[k]), longint'(eq[j].s));
                last_v[k] = eq[j].v;
                last_s[k] = eq[j].s;
                eq.delete(j);
                if (k == 0) begin cap_a.push_back(longint'(dq[k])); capcyc_a.push_back(cyc); end
                if (k == 2) begin cap_c.push_back(longint'(dq[k])); capcyc_c.push_back(cyc); end
            end else begin
                check($sformatf("idle%0d", k), longint'(ov[k]), 0);
                check($sformatf("hold%0d", k), longint'(dq[k]), last_v[k]);
                check($sformatf("holdsat%0d", k), longint'(sq[k]), longint'(last_s[k]));
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        model_edge();
        #1;
        check_all();
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0; clear = 1'b0; coef_we = 1'b0;
        repeat (n) tick();
    endtask

    task automatic put(input longint x);
        in_valid = 1'b1;
        data_in  = DW'(x);
        tick();
    endtask

    task automatic wcoef(input int a, input longint v);
        coef_we   = 1'b1;
        coef_addr = 4'(a);
        coef_data = CW'(v);
        tick();
        coef_we = 1'b0;
    endtask

    task automatic do_reset();
        in_valid = 1'b0; clear = 1'b0; coef_we = 1'b0;
        reset_b = 1'b0;
        #2;
        model_reset();
        for (int k = 0; k < 3; k++) begin
            check($sformatf("rst_valid%0d", k), longint'(ov[k]), 0);
            check($sformatf("rst_data%0d", k), longint'(dq[k]), 0);
            check($sformatf("rst_sat%0d", k), longint'(sq[k]), 0);
        end
        @(posedge clk);
        #1;
        reset_b = 1'b1;
    endtask

    task automatic do_clear();
        clear = 1'b1; in_valid = 1'b1; data_in = DW'(12345);
        tick();
        check("clr_valid", longint'(ov[0]), 0);
        clear = 1'b0; in_valid = 1'b0;
    endtask

    task automatic program_ramp();
        idle(2);
        for (int i = 0; i < NC; i++) wcoef(i, i + 1);
        wcoef(12, 777);
        wcoef(15, -5);
    endtask

    task automatic set_coefs(input longint c0, input longint c11);
        idle(2);
        for (int i = 0; i < NC; i++) wcoef(i, (i == 0) ? c0 : ((i == NC - 1) ? c11 : 0));
    endtask

    task automatic impulse_check(input string tag);
        int n0;
        cap_a.delete(); capcyc_a.delete();
        put(1);
        n0 = cyc;
        repeat (30) put(0);
        idle(6);
        check({tag, "_count"}, cap_a.size(), 31);
        if (capcyc_a.size() > 0) check({tag, "_latency"}, capcyc_a[0], n0 + 4);
        for (int i = 0; i < 31 && i < cap_a.size(); i++)
            check({tag, "_tap"}, cap_a[i], (i < 12) ? i + 1 : ((i < 24) ? 24 - i : 0));
    endtask

    function automatic longint rnd_coef();
        int m;
        m = int'($urandom_range(20, 2));
        return longint'($urandom_range((1 << m) - 1, 0)) - (longint'(1) << (m - 1));
    endfunction

    initial begin
        int s0, guard, nw;

        do_reset();

        program_ramp();
        impulse_check("imp");

        set_coefs(0, 1 << 18);
        repeat (40) put(1000);
        check("dc_unity", longint'(dq[1]), 1000);
        set_coefs(0, (1 << 19) - 1);
        repeat (40) put(131071);
        check("dc_nosat", longint'(sq[1]), 0);
        set_coefs((1 << 19) - 1, (1 << 19) - 1);
        repeat (40) put(524287);
        check("sat_pos_data", longint'(dq[1]), 524287);
        check("sat_pos_flag", longint'(sq[1]), 1);
        repeat (40) put(-524288);
        check("sat_neg_data", longint'(dq[1]), -524288);
        check("sat_neg_flag", longint'(sq[1]), 1);

        set_coefs(0, 1);
        do_clear();
        cap_c.delete();
        put(1);
        repeat (14) put(0);
        idle(6);
        check("rnd_count", cap_c.size(), 5);
        if (cap_c.size() == 5) check("rnd_half_up", cap_c[4], 1);
        do_clear();
        cap_c.delete();
        put(-1);
        repeat (14) put(0);
        idle(6);
        if (cap_c.size() == 5) check("rnd_neg_half", cap_c[4], 0);

        do_clear();
        capcyc_c.delete();
        s0 = 0;
        for (int i = 0; i < 20; i++) begin
            in_valid = (i % 2 == 0);
            data_in  = DW'(i * 100);
            tick();
            if (i == 0) s0 = cyc;
        end
        idle(6);
        check("dec_count", capcyc_c.size(), 4);
        if (capcyc_c.size() >= 2) begin
            check("dec_first", capcyc_c[0], s0 + 4);
            check("dec_spacing", capcyc_c[1] - capcyc_c[0], 6);
        end

        program_ramp();
        cap_a.delete();
        put(1);
        guard = 0;
        while (cap_a.size() < 10 && guard < 40) begin
            put(0);
            guard++;
        end
        check("clr_reach10", cap_a.size(), 10);
        do_clear();
        idle(1);
        impulse_check("clr_imp");

        for (int i = 0; i < 8; i++) put(longint'($signed(DW'($urandom))));
        do_reset();
        impulse_check_zero: begin
            cap_a.delete();
            put(1);
            repeat (30) put(0);
            idle(6);
            check("rst_imp_count", cap_a.size(), 31);
            for (int i = 0; i < cap_a.size(); i++) check("rst_imp_zero", cap_a[i], 0);
        end

        for (int ep = 0; ep < 8; ep++) begin
            idle(2);
            nw = int'($urandom_range(6, 1));
            for (int w = 0; w < nw; w++) begin
                in_valid = (w == nw - 1);
                data_in  = DW'($urandom);
                wcoef(int'($urandom_range(15, 0)), rnd_coef());
            end
            for (int i = 0; i < 80; i++) begin
                in_valid = ($urandom_range(3, 0) != 0);
                data_in  = DW'($urandom);
                clear    = ($urandom_range(49, 0) == 0);
                tick();
            end
            clear = 1'b0;
        end
        idle(6);
        check("drain_empty", eq.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
